imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side companion to the instruction fetch path. Receives a byte stream over a valid/ready link and packs it into 32-bit big-endian words.
- Writes the words into the instruction memory write port at consecutive word-aligned byte addresses.
- Holds the fetch stage (cpu_hold drives the fetch enable low) for the whole load and pulses done when the image is in place.

Parameters:
- ADDR_WIDTH, 10, byte address width of the instruction memory; low 2 bits always 0.
- MAX_WORDS, 256, maximum image length in words; must equal 2**(ADDR_WIDTH-2).
- LEN_WIDTH, 16, width of the length header in the byte stream.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- start  input  1  single-cycle request to begin a load; honoured only in IDLE or ERR
- rx_data  input  8  stream byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  instruction memory write strobe, one cycle per word
- mem_addr  output  ADDR_WIDTH  byte address of the write, equal to word_index*4
- mem_wdata  output  32  assembled word
- cpu_hold  output  1  high while loading; fetch enable = ~cpu_hold
- busy  output  1  high in any state other than IDLE, DONE or ERR
- done  output  1  single-cycle pulse on successful completion
- error  output  1  sticky flag for a bad length header
- word_count  output  ADDR_WIDTH-1  number of words written in the current or last load

Behaviour:
- Reset (async): state IDLE, and every output at 0: rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error, word_count. Byte counter and word index are cleared.
- A byte is transferred only in a cycle where rx_valid and rx_ready are both 1. rx_data is ignored in every other cycle.
- State IDLE: rx_ready=0. On start, go to LEN_HI and clear word_count.
- State LEN_HI: rx_ready=1. On transfer, latch len[15:8] and go to LEN_LO.
- State LEN_LO: rx_ready=1. On transfer, latch len[7:0] and check {len_hi,rx_data}:
  - 0 or greater than MAX_WORDS: go to ERR.
  - otherwise: go to DATA with byte count 0.
- State DATA: rx_ready=1. Bytes pack MSB-first: 1st byte goes to [31:24], 4th byte to [7:0].
  - On the 4th transfer, go to WRITE.
- State WRITE: rx_ready=0. The registered outputs are mem_we=1, mem_addr=word_index<<2 and mem_wdata=assembled word.
  - They appear exactly one cycle after the 4th byte handshake and last one cycle.
  - word_index and word_count increment.
  - If the incremented index equals len, go to DONE; otherwise go to DATA.
- State DONE: done=1 for one cycle, cpu_hold drops to 0 in the same cycle, then go to IDLE. word_count holds its value.
- State ERR: error=1 and cpu_hold=0, held until the next start or reset. start in ERR clears error and goes to LEN_HI.
- cpu_hold=1 in LEN_HI, LEN_LO, DATA and WRITE; 0 otherwise.
- start outside IDLE/ERR is ignored. A load in progress is never restarted by start.
- rx_valid may be deasserted at any time. The FSM waits indefinitely, with no timeout.
- mem_addr is ADDR_WIDTH bits and word_index never exceeds MAX_WORDS-1, so it never wraps. len==MAX_WORDS writes the final word at address 4*(MAX_WORDS-1).
- Reset mid-load: immediate return to IDLE. Words already written stay in memory, with no rollback. cpu_hold is released.
- mem_wdata holds its last value when mem_we=0.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR;
  - BYTES_PER_WORD=4;
  - the length-check constant MAX_WORDS.
- One sub-module, byte_packer: a 2-bit byte counter plus a 32-bit shift register. It has inputs clr and shift_en, and outputs word and word_full. The FSM, counters and memory-port registers stay in imem_loader.

Test Plan:
- Basic load: start; stream 00 02 12 34 56 78 9A BC DE F0 with rx_valid always 1. Required response:
  - mem_we at addr 0x000 with 0x12345678, then at addr 0x004 with 0x9ABCDEF0;
  - done pulses once and word_count=2;
  - cpu_hold is high from the cycle after start until done.
- Backpressure and gaps: the same image with rx_valid toggled randomly. Writes are identical, and rx_ready=0 during the WRITE cycles.
- Length errors:
  - header 00 00 gives error=1 and cpu_hold=0, with no mem_we;
  - header 01 01 (257) gives error=1;
  - a subsequent start plus a valid 00 01 AA BB CC DD clears error and writes 0xAABBCCDD at 0x000.
- Full memory: len=0x0100 with 1024 bytes. The last write is at addr 0x3FC, word_count=256 and done=1.
- Reset mid-load: assert reset after 6 data bytes of a 4-word image. All outputs are 0 immediately. A following start and full image load completes normally.
- start ignored while busy: pulse start during DATA. The load continues unchanged and done pulses exactly once.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned MAX_WORDS      = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects stream bytes MSB-first; the fourth byte completes the word on the fly
// so the loader can register the full word on the same edge it accepts that byte.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        shift_en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);
  localparam int unsigned SR_W  = 8 * (BYTES_PER_WORD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [SR_W-1:0]  sr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (shift_en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
      sr_q  <= {sr_q[SR_W-9:0], data_i};
    end
  end

  assign word_o      = {sr_q, data_i};
  assign word_full_o = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory as big-endian
// words while holding the fetch stage; pulses done or flags a bad length.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned MAX_WORDS  = imem_loader_pkg::MAX_WORDS,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-2:0] word_count
);
  import imem_loader_pkg::*;

  localparam int unsigned IDX_W = ADDR_WIDTH - 1;
  localparam int unsigned HI_W  = LEN_WIDTH - 8;

  state_e                state_q, state_d;
  logic [HI_W-1:0]       len_hi_q, len_hi_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      word_count_q, word_count_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  pk_clr, pk_shift, pk_full;
  logic [31:0]           pk_word;
  logic                  xfer_c;
  logic [LEN_WIDTH-1:0]  len_c;
  logic                  len_bad_c;
  logic                  last_word_c;

  imem_loader_byte_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (pk_clr),
    .shift_en_i  (pk_shift),
    .data_i      (rx_data),
    .word_o      (pk_word),
    .word_full_o (pk_full)
  );

  assign xfer_c      = rx_valid && rx_ready_q;
  assign len_c       = {len_hi_q, rx_data};
  assign len_bad_c   = (len_c == '0) || (len_c > LEN_WIDTH'(MAX_WORDS));
  assign last_word_c = ((LEN_WIDTH'(idx_q) + LEN_WIDTH'(1)) == len_q);

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_hi_q     <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      word_count_q <= '0;
      rx_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_hold_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      word_count_q <= word_count_d;
      rx_ready_q   <= rx_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Next state; output registers are decoded from the next state
  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    len_d        = len_q;
    idx_d        = idx_q;
    word_count_d = word_count_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    error_d      = error_q;
    pk_clr       = 1'b0;
    pk_shift     = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          state_d      = ST_LEN_HI;
          error_d      = 1'b0;
          word_count_d = '0;
          idx_d        = '0;
          pk_clr       = 1'b1;
        end
      end
      ST_LEN_HI: begin
        if (xfer_c) begin
          len_hi_d = HI_W'(rx_data);
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (xfer_c) begin
          len_d = len_c;
          if (len_bad_c) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end else begin
            state_d = ST_DATA;
            pk_clr  = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (xfer_c) begin
          pk_shift = 1'b1;
          if (pk_full) begin
            state_d     = ST_WRITE;
            mem_addr_d  = {idx_q[ADDR_WIDTH-3:0], 2'b00};
            mem_wdata_d = pk_word;
          end
        end
      end
      ST_WRITE: begin
        idx_d        = idx_q + IDX_W'(1);
        word_count_d = word_count_q + IDX_W'(1);
        state_d      = last_word_c ? ST_DONE : ST_DATA;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rx_ready_d = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) || (state_d == ST_DATA);
    cpu_hold_d = rx_ready_d || (state_d == ST_WRITE);
    busy_d     = cpu_hold_d;
    mem_we_d   = (state_d == ST_WRITE);
    done_d     = (state_d == ST_DONE);
  end

  assign rx_ready   = rx_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte-stream loads, length errors, full image,
// mid-load reset and ignored start, checked with immediate assertions.
module tb_imem_loader;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-2:0] word_count;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int wr_ready_viol = 0;
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  logic [7:0]    img[$];
  int base_w, base_d, nm;
  logic [31:0]   exp_w;
  logic [63:0]   outs;

  imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(256), .LEN_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  assign outs = 64'({rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error, word_count});

  // Write/done recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        wa_q.push_back(mem_addr);
        wd_q.push_back(mem_wdata);
        if (rx_ready) wr_ready_viol++;
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("send_timeout", 64'(n), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic send_all(input int gapmax);
    for (int i = 0; i < img.size(); i++)
      send_byte(img[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done), 64'(1));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", outs, 64'(0));
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_not_ready", 64'(rx_ready), 64'(0));

    // Basic two-word load, rx_valid held high
    base_w = wa_q.size(); base_d = done_cnt;
    pulse_start();
    chk("start_hold_busy_ready", 64'({cpu_hold, busy, rx_ready}), 64'(3'b111));
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
    send_all(0);
    @(negedge clk);
    chk("we_after_4th_byte", 64'(mem_we), 64'(1));
    chk("write_cycle_wdata", 64'(mem_wdata), 64'(32'h12345678));
    chk("ready_low_in_write", 64'(rx_ready), 64'(0));
    chk("hold_in_write", 64'(cpu_hold), 64'(1));
    img = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_all(0);
    wait_done("basic");
    chk("basic_hold_drop_at_done", 64'(cpu_hold), 64'(0));
    chk("basic_wc", 64'(word_count), 64'(2));
    @(posedge clk); #1;
    chk("basic_done_pulse_len", 64'(done), 64'(0));
    chk("basic_wc_holds", 64'(word_count), 64'(2));
    chk("basic_nwrites", 64'(wa_q.size() - base_w), 64'(2));
    chk("basic_a0", 64'(wa_q[base_w]), 64'(10'h000));
    chk("basic_d0", 64'(wd_q[base_w]), 64'(32'h12345678));
    chk("basic_a1", 64'(wa_q[base_w+1]), 64'(10'h004));
    chk("basic_d1", 64'(wd_q[base_w+1]), 64'(32'h9ABCDEF0));
    chk("basic_done_once", 64'(done_cnt - base_d), 64'(1));

    // Same image with random rx_valid gaps
    base_w = wa_q.size();
    pulse_start();
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_all(3);
    wait_done("gaps");
    @(posedge clk); #1;
    chk("gaps_nwrites", 64'(wa_q.size() - base_w), 64'(2));
    chk("gaps_d0", 64'(wd_q[base_w]), 64'(32'h12345678));
    chk("gaps_a1", 64'(wa_q[base_w+1]), 64'(10'h004));
    chk("gaps_d1", 64'(wd_q[base_w+1]), 64'(32'h9ABCDEF0));
    chk("ready_low_during_writes", 64'(wr_ready_viol), 64'(0));

    // Zero length header
    base_w = wa_q.size();
    pulse_start();
    img = '{8'h00, 8'h00};
    send_all(0);
    @(negedge clk);
    chk("len0_err_hold_busy", 64'({error, cpu_hold, busy}), 64'(3'b100));
    repeat (3) @(posedge clk); #1;
    chk("len0_err_sticky", 64'(error), 64'(1));
    chk("len0_no_writes", 64'(wa_q.size() - base_w), 64'(0));

    // Length 257, restarted from ERR
    pulse_start();
    chk("err_cleared_by_start", 64'({error, cpu_hold}), 64'(2'b01));
    img = '{8'h01, 8'h01};
    send_all(0);
    @(negedge clk);
    chk("len257_err", 64'({error, cpu_hold}), 64'(2'b10));

    // Recovery with a valid one-word image
    base_w = wa_q.size();
    pulse_start();
    img = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_all(0);
    wait_done("recover");
    chk("recover_err_clear", 64'(error), 64'(0));
    chk("recover_wc", 64'(word_count), 64'(1));
    @(posedge clk); #1;
    chk("recover_nwrites", 64'(wa_q.size() - base_w), 64'(1));
    chk("recover_a0", 64'(wa_q[base_w]), 64'(10'h000));
    chk("recover_d0", 64'(wd_q[base_w]), 64'(32'hAABBCCDD));

    // Full memory: 256 words of {i, C3, ~i, 5A}
    base_w = wa_q.size();
    pulse_start();
    img = '{8'h01, 8'h00};
    for (int i = 0; i < 256; i++) begin
      img.push_back(8'(i));
      img.push_back(8'hC3);
      img.push_back(~8'(i));
      img.push_back(8'h5A);
    end
    send_all(0);
    wait_done("full");
    chk("full_wc", 64'(word_count), 64'(256));
    @(posedge clk); #1;
    chk("full_nwrites", 64'(wa_q.size() - base_w), 64'(256));
    chk("full_last_addr", 64'(wa_q[base_w+255]), 64'(10'h3FC));
    chk("full_last_data", 64'(wd_q[base_w+255]), 64'(32'hFFC3005A));
    nm = 0;
    for (int i = 0; i < 256 && (base_w + i) < wa_q.size(); i++) begin
      exp_w = {8'(i), 8'hC3, ~8'(i), 8'h5A};
      if (wa_q[base_w+i] !== AW'(4*i) || wd_q[base_w+i] !== exp_w) nm++;
    end
    chk("full_all_words", 64'(nm), 64'(0));

    // Reset after 6 data bytes of a 4-word image
    base_w = wa_q.size();
    pulse_start();
    img = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_all(0);
    reset = 1'b1;
    #1;
    chk("midreset_outputs", outs, 64'(0));
    chk("midreset_first_word_written", 64'(wd_q[wd_q.size()-1]), 64'(32'h11223344));
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    base_w = wa_q.size();
    pulse_start();
    img = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
            8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00};
    send_all(1);
    wait_done("reload");
    chk("reload_wc", 64'(word_count), 64'(4));
    @(posedge clk); #1;
    chk("reload_nwrites", 64'(wa_q.size() - base_w), 64'(4));
    chk("reload_a2", 64'(wa_q[base_w+2]), 64'(10'h008));
    chk("reload_d2", 64'(wd_q[base_w+2]), 64'(32'h99AABBCC));
    chk("reload_a3", 64'(wa_q[base_w+3]), 64'(10'h00C));
    chk("reload_d3", 64'(wd_q[base_w+3]), 64'(32'hDDEEFF00));

    // start pulsed during DATA is ignored
    base_w = wa_q.size(); base_d = done_cnt;
    pulse_start();
    img = '{8'h00, 8'h02, 8'h01, 8'h02};
    send_all(0);
    pulse_start();
    chk("ign_start_still_loading", 64'({busy, cpu_hold, rx_ready, error}), 64'(4'b1110));
    img = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_all(0);
    wait_done("ign");
    chk("ign_wc", 64'(word_count), 64'(2));
    repeat (3) @(posedge clk); #1;
    chk("ign_done_once", 64'(done_cnt - base_d), 64'(1));
    chk("ign_nwrites", 64'(wa_q.size() - base_w), 64'(2));
    chk("ign_d0", 64'(wd_q[base_w]), 64'(32'h01020304));
    chk("ign_d1", 64'(wd_q[base_w+1]), 64'(32'h05060708));
    chk("ign_idle", 64'({busy, cpu_hold, done}), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
